ps_run_ctrl: RTL and testbench
==============================

# ps_run_ctrl

Run controller on the upstream and downstream side of the 16-bit pipelined processor. It streams a program into instruction memory (IM) and pulses the processor's `start`. It then counts cycles until the processor raises `stop`, and streams a range of data memory (DM) out for checking. It owns IM's write port and, outside RUN, DM's address and read port through an external mux selected by `dm_sel`.

## Interface
- `ADDR_WIDTH`, 8: IM/DM address width.
- `DATA_WIDTH`, 16: IM/DM word width.
- `CNT_WIDTH`, 16: run cycle counter width.
- `STOP_MASK`, 4: number of initial RUN cycles during which `ps_stop` is ignored.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_go` in 1: start-sequence pulse.
- `prog_len` in ADDR_WIDTH+1: words to load; sampled on an accepted `cfg_go`.
- `dump_base` in ADDR_WIDTH: first DM address to dump; sampled on an accepted `cfg_go`.
- `dump_len` in ADDR_WIDTH+1: words to dump; sampled on an accepted `cfg_go`.
- `ld_valid` in 1: program stream valid.
- `ld_ready` out 1: program stream ready.
- `ld_data` in DATA_WIDTH: program word.
- `im_wr` out 1: IM write enable.
- `im_w_addr` out ADDR_WIDTH: IM write address.
- `im_w_data` out DATA_WIDTH: IM write data.
- `ps_start` out 1: processor start.
- `ps_stop` in 1: processor stop (level).
- `dm_sel` out 1: 1 = this block drives DM address/read.
- `dm_addr` out ADDR_WIDTH: DM read address.
- `dm_rd` out 1: DM read enable.
- `dm_r_data` in DATA_WIDTH: DM read data, valid the cycle after `dm_rd`.
- `dp_valid` out 1: dump stream valid.
- `dp_ready` in 1: dump stream ready.
- `dp_data` out DATA_WIDTH: dumped word.
- `busy` out 1: state is not IDLE, DONE or ERR.
- `done` out 1: sequence completed.
- `err` out 1: run timeout.
- `run_cycles` out CNT_WIDTH: cycles spent in RUN.

## Operation
- **States:** IDLE, LOAD, START, RUN, DUMP_RD, DUMP_WT, DONE, ERR.
- **Accepting `cfg_go`:** only in IDLE, DONE or ERR; ignored in every other state. On accept:
  - latch the config inputs;
  - clear `done`, `err`, `run_cycles` and the load/dump counters;
  - go to LOAD, or to START if `prog_len` is 0.
- **Length clamp:** `prog_len` and `dump_len` values above 2^ADDR_WIDTH are treated as 2^ADDR_WIDTH.
- **LOAD:**
  - `ld_ready` = 1.
  - Each handshake (`ld_valid & ld_ready`) registers `im_wr` = 1, `im_w_addr` = load count and `im_w_data` = `ld_data` for the next cycle, then increments the count.
  - The handshake that brings the count to `prog_len` moves the FSM to START.
  - Without `ld_valid`, LOAD waits indefinitely.
- **START:** `ps_start` = 1 for exactly this one cycle, then RUN. The final IM write commits no later than this cycle's edge.
- **RUN:**
  - `run_cycles` increments every cycle and saturates at all-ones.
  - `ps_stop` is ignored while `run_cycles` < STOP_MASK.
  - Once unmasked, `ps_stop` = 1 moves to DUMP_RD, or to DONE if `dump_len` is 0.
  - If `run_cycles` reaches 2^CNT_WIDTH−1 without a stop, go to ERR.
  - `dm_sel` = 0 throughout RUN.
- **DUMP_RD:**
  - `dm_sel` = 1, `dm_rd` = 1, `dm_addr` = (`dump_base` + dump count) mod 2^ADDR_WIDTH; the address wraps.
  - Always lasts one cycle, then DUMP_WT.
- **DUMP_WT:**
  - On the first cycle, capture `dm_r_data` into `dp_data`; `dp_valid` = 1 from that point.
  - `dp_data` holds stable while `dp_valid & !dp_ready`.
  - On handshake, increment the dump count; go to DONE if count equals `dump_len`, otherwise back to DUMP_RD.
- **DONE:** `done` = 1 and `dm_sel` = 1. Hold until `cfg_go` or `rst`.
- **ERR:** `err` = 1 and `dm_sel` = 0. Hold until `cfg_go` or `rst`.
- **Outputs outside their active state:** `dm_rd`, `im_wr`, `ps_start` and `dp_valid` are 0.

## Timing
- **Reset:** `rst` at any edge, including mid-LOAD, mid-RUN and mid-dump, returns the FSM to IDLE on the next cycle and clears all outputs:
  - `ld_ready`, `im_wr`, `ps_start`, `dm_sel`, `dm_rd`, `dp_valid`, `busy`, `done`, `err` = 0;
  - `im_w_addr`, `im_w_data`, `dm_addr`, `dp_data`, `run_cycles` = 0.
- **Load throughput:** 1 word/cycle. The IM write lags its handshake by 1 cycle.
- **`cfg_go` to `ps_start`:** 1 + `prog_len` cycles with continuous `ld_valid`.
- **`run_cycles` at stop:** the count of RUN cycles up to and including the cycle `ps_stop` is sampled high.
- **Dump throughput:** at most 1 word per 2 cycles. `dp_valid` rises 2 cycles after entry to DUMP_RD.
- **Simultaneous events:**
  - `cfg_go` in DONE re-arms immediately; `done` falls the next cycle.
  - `rst` has priority over `cfg_go`.
  - `ps_stop` and timeout in the same cycle: stop wins.

## Test plan
- **Basic load and start:** `prog_len`=3, words 0xA001/0xA002/0xA003 with continuous valid → IM writes at addresses 0, 1, 2 on cycles 2–4; `ps_start` high exactly 1 cycle.
- **Stop masking:** `ps_stop` already high on entering RUN, STOP_MASK=4 → stop taken at `run_cycles`=5; a later `ps_stop` at cycle 40 → `run_cycles`=40.
- **Dump with backpressure and wrap:** `dump_base`=0xFE, `dump_len`=3, DM[0xFE]=0x1111, DM[0xFF]=0x2222, DM[0x00]=0x3333, `dp_ready` low 3 cycles on word 2 → stream 0x1111, 0x2222, 0x3333 with `dp_data` stable while stalled; then `done`=1.
- **Zero lengths:** `prog_len`=0, `dump_len`=0 → `cfg_go`, START, RUN, DONE with no `im_wr` and no `dm_rd`.
- **Timeout:** `CNT_WIDTH`=6, `ps_stop` held 0 → `err`=1 at `run_cycles`=63 and `dm_sel`=0; a fresh `cfg_go` clears `err`.
- **Reset mid-operation:** `rst` asserted during LOAD after 2 words, and again during DUMP_WT with `dp_valid`=1 → all outputs 0 the next cycle, FSM in IDLE, `cfg_go` during `rst` ignored.

Source files
------------

// File: rtl/ps_run_ctrl.sv
// Run controller for the 16-bit pipelined processor: streams a program into IM,
// pulses start, times the run until stop, then streams a DM window out.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for cfg_go after reset
// S_LOAD    | accepting program words, writing IM
// S_START   | one-cycle ps_start pulse
// S_RUN     | processor running, cycle counter active, stop masked early on
// S_DUMP_RD | DM read issued for the current dump word
// S_DUMP_WT | capture DM data, then offer it on the dump stream
// S_DONE    | sequence complete, DM still owned by this block
// S_ERR     | run timed out, DM handed back to the processor side
module ps_run_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int STOP_MASK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_go,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic [ADDR_WIDTH-1:0] dump_base,
    input  logic [ADDR_WIDTH:0]   dump_len,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  im_wr,
    output logic [ADDR_WIDTH-1:0] im_w_addr,
    output logic [DATA_WIDTH-1:0] im_w_data,
    output logic                  ps_start,
    input  logic                  ps_stop,
    output logic                  dm_sel,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  dm_rd,
    input  logic [DATA_WIDTH-1:0] dm_r_data,
    output logic                  dp_valid,
    input  logic                  dp_ready,
    output logic [DATA_WIDTH-1:0] dp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  run_cycles
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP_RD, S_DUMP_WT, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH:0]  MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] MASK_CNT = CNT_WIDTH'(STOP_MASK);

    state_t                state;
    logic [ADDR_WIDTH:0]   prog_len_q, dump_len_q, ld_cnt, dp_cnt;
    logic [ADDR_WIDTH-1:0] dump_base_q;
    logic [ADDR_WIDTH:0]   ld_cnt_inc, dp_cnt_inc, prog_len_clamp, dump_len_clamp;
    logic [CNT_WIDTH-1:0]  run_inc;
    logic                  accept, stop_hit;

    assign ld_cnt_inc     = ld_cnt + 1'b1;
    assign dp_cnt_inc     = dp_cnt + 1'b1;
    assign prog_len_clamp = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign dump_len_clamp = (dump_len > MAX_LEN) ? MAX_LEN : dump_len;
    assign run_inc        = (&run_cycles) ? run_cycles : run_cycles + 1'b1;
    assign accept         = cfg_go && (state == S_IDLE || state == S_DONE || state == S_ERR);
    // run_cycles still holds the pre-increment count here, so the mask covers
    // exactly the first STOP_MASK RUN cycles.
    assign stop_hit       = ps_stop && (run_cycles >= MASK_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prog_len_q  <= '0;
            dump_len_q  <= '0;
            dump_base_q <= '0;
            ld_cnt      <= '0;
            dp_cnt      <= '0;
            ld_ready    <= 1'b0;
            im_wr       <= 1'b0;
            im_w_addr   <= '0;
            im_w_data   <= '0;
            ps_start    <= 1'b0;
            dm_sel      <= 1'b0;
            dm_addr     <= '0;
            dm_rd       <= 1'b0;
            dp_valid    <= 1'b0;
            dp_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            run_cycles  <= '0;
        end else begin
            im_wr    <= 1'b0;
            ps_start <= 1'b0;
            dm_rd    <= 1'b0;
            if (accept) begin
                prog_len_q  <= prog_len_clamp;
                dump_len_q  <= dump_len_clamp;
                dump_base_q <= dump_base;
                ld_cnt      <= '0;
                dp_cnt      <= '0;
                run_cycles  <= '0;
                done        <= 1'b0;
                err         <= 1'b0;
                busy        <= 1'b1;
                dm_sel      <= 1'b0;
                dp_valid    <= 1'b0;
                if (prog_len_clamp == '0) begin
                    state    <= S_START;
                    ps_start <= 1'b1;
                end else begin
                    state    <= S_LOAD;
                    ld_ready <= 1'b1;
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        if (ld_valid) begin
                            im_wr     <= 1'b1;
                            im_w_addr <= ld_cnt[ADDR_WIDTH-1:0];
                            im_w_data <= ld_data;
                            ld_cnt    <= ld_cnt_inc;
                            if (ld_cnt_inc == prog_len_q) begin
                                ld_ready <= 1'b0;
                                ps_start <= 1'b1;
                                state    <= S_START;
                            end
                        end
                    end
                    S_START: state <= S_RUN;
                    S_RUN: begin
                        run_cycles <= run_inc;
                        if (stop_hit) begin
                            dm_sel <= 1'b1;
                            if (dump_len_q == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= S_DUMP_RD;
                                dm_rd   <= 1'b1;
                                dm_addr <= dump_base_q;
                            end
                        end else if (&run_inc) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    S_DUMP_RD: state <= S_DUMP_WT;
                    S_DUMP_WT: begin
                        // dp_valid low marks the first WT cycle, when read data is on the bus
                        if (!dp_valid) begin
                            dp_data  <= dm_r_data;
                            dp_valid <= 1'b1;
                        end else if (dp_ready) begin
                            dp_valid <= 1'b0;
                            dp_cnt   <= dp_cnt_inc;
                            if (dp_cnt_inc == dump_len_q) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= S_DUMP_RD;
                                dm_rd   <= 1'b1;
                                dm_addr <= dump_base_q + dp_cnt_inc[ADDR_WIDTH-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps_run_ctrl.sv
// Bench for ps_run_ctrl: directed and randomized run sequences checked against
// expectations computed from lengths, stop timing and a DM/IM array model.
module tb_ps_run_ctrl;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 6;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst, cfg_go, ld_valid, ld_ready, im_wr, ps_start, ps_stop;
    logic          dm_sel, dm_rd, dp_valid, dp_ready, busy, done, err;
    logic [AW:0]   prog_len, dump_len;
    logic [AW-1:0] dump_base, im_w_addr, dm_addr;
    logic [DW-1:0] ld_data, im_w_data, dm_r_data, dp_data;
    logic [CW-1:0] run_cycles;

    ps_run_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STOP_MASK(SM)) dut (
        .clk(clk), .rst(rst), .cfg_go(cfg_go), .prog_len(prog_len), .dump_base(dump_base),
        .dump_len(dump_len), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .im_wr(im_wr), .im_w_addr(im_w_addr), .im_w_data(im_w_data), .ps_start(ps_start),
        .ps_stop(ps_stop), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_rd(dm_rd),
        .dm_r_data(dm_r_data), .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
        .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cfg_cyc = 0;
    int im_wr_cnt, start_cnt, dm_rd_cnt;
    int last_rd_cyc = 0;
    logic [DW-1:0] dm_mem [256];
    logic [DW-1:0] im_log [256];
    int            im_cyc [256];
    logic [DW-1:0] dump_q [$];
    logic          dp_valid_d = 1'b0;
    logic          stall_d = 1'b0;
    logic [DW-1:0] dp_data_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; DM answers with one cycle of latency, garbage otherwise.
    task automatic tick();
        logic          rd;
        logic [AW-1:0] a;
        rd = dm_rd;
        a  = dm_addr;
        @(posedge clk);
        #1;
        cyc++;
        dm_r_data = rd ? dm_mem[a] : DW'($urandom);
    endtask

    always @(negedge clk) begin
        if (im_wr) begin
            im_log[im_w_addr] = im_w_data;
            im_cyc[im_w_addr] = cyc - cfg_cyc;
            im_wr_cnt++;
        end
        if (ps_start) start_cnt++;
        if (dm_rd) begin
            dm_rd_cnt++;
            last_rd_cyc = cyc;
            chk("dm_rd_sel", 64'(dm_sel), 64'd1);
        end
        if (dp_valid && !dp_valid_d) chk("dp_valid_lat", 64'(cyc - last_rd_cyc), 64'd2);
        if (stall_d) chk("dp_hold", 64'({dp_valid, dp_data}), 64'({1'b1, dp_data_d}));
        if (dp_valid && dp_ready) dump_q.push_back(dp_data);
        stall_d    = dp_valid && !dp_ready && !rst;
        dp_valid_d = dp_valid;
        dp_data_d  = dp_data;
    end

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_ctl"}, 64'({ld_ready, im_wr, ps_start, dm_sel, dm_rd, dp_valid, busy, done, err}), 64'd0);
        chk({tag, "_bus"}, 64'({im_w_addr, im_w_data, dm_addr, dp_data, run_cycles}), 64'd0);
    endtask

    // abort: 0 run to completion, 1 return after two load handshakes, 2 return once dp_valid is up
    task automatic run_seq(input int plen, input int base, input int dlen, input int stop_at,
                           input int ld_pct, input int rdy_pct, input int stall_w,
                           input logic [DW-1:0] w0, input int abort);
        logic [DW-1:0] words [$];
        int eff_p, eff_d, idx, start_cyc, guard, stall_n, run_exp;
        bit exp_err;
        eff_p = (plen > 256) ? 256 : plen;
        eff_d = (dlen > 256) ? 256 : dlen;
        for (int i = 0; i < eff_p; i++) words.push_back((w0 != 0) ? w0 + DW'(i) : DW'($urandom));
        for (int i = 0; i < 256; i++) im_log[i] = 'x;
        dump_q.delete();
        im_wr_cnt = 0; start_cnt = 0; dm_rd_cnt = 0;
        idx = 0; start_cyc = -1; stall_n = 0; guard = 0;
        cfg_go = 1'b1; prog_len = 9'(plen); dump_base = 8'(base); dump_len = 9'(dlen);
        ld_valid = 1'b0; ps_stop = 1'b0; dp_ready = 1'b0;
        cfg_cyc = cyc;
        tick();
        cfg_go = 1'b0; prog_len = 9'($urandom); dump_base = 8'($urandom); dump_len = 9'($urandom);
        chk("accept_clr", 64'({busy, done, err, run_cycles}), 64'({3'b100, 6'd0}));
        while (!(done || err) && guard < 3000) begin
            if (abort == 1 && idx == 2) return;
            if (abort == 2 && dp_valid) begin
                dp_ready = 1'b0;
                return;
            end
            if (ps_start) start_cyc = cyc;
            cfg_go   = (start_cyc >= 0 && cyc - start_cyc == 2);
            ld_valid = (idx < eff_p) && ($urandom_range(99) < ld_pct);
            ld_data  = ld_valid ? words[idx] : DW'($urandom);
            if (ld_valid && ld_ready) idx++;
            ps_stop = (stop_at > 0 && start_cyc >= 0 && cyc - start_cyc >= stop_at);
            if (dp_valid && dump_q.size() == stall_w && stall_n < 3) begin
                dp_ready = 1'b0;
                stall_n++;
            end else begin
                dp_ready = ($urandom_range(99) < rdy_pct);
            end
            tick();
            guard++;
        end
        cfg_go = 1'b0; ld_valid = 1'b0; ps_stop = 1'b0; dp_ready = 1'b0;
        chk("seq_bound", 64'(guard < 3000), 64'd1);
        exp_err = (stop_at == 0 || stop_at > 63);
        run_exp = exp_err ? 63 : ((stop_at > SM) ? stop_at : SM + 1);
        chk("start_pulses", 64'(start_cnt), 64'd1);
        if (ld_pct == 100) chk("cfg_to_start", 64'(start_cyc - cfg_cyc), 64'(1 + eff_p));
        chk("im_writes", 64'(im_wr_cnt), 64'(eff_p));
        for (int i = 0; i < eff_p; i++) begin
            chk("im_word", 64'(im_log[i]), 64'(words[i]));
            if (ld_pct == 100) chk("im_wr_cycle", 64'(im_cyc[i]), 64'(i + 2));
        end
        chk("end_flags", 64'({busy, done, err, dm_sel}), 64'({1'b0, !exp_err, exp_err, !exp_err}));
        chk("run_cycles", 64'(run_cycles), 64'(run_exp));
        chk("dm_reads", 64'(dm_rd_cnt), 64'(exp_err ? 0 : eff_d));
        if (!exp_err) begin
            chk("dump_words", 64'(dump_q.size()), 64'(eff_d));
            for (int i = 0; i < eff_d && i < dump_q.size(); i++)
                chk("dump_data", 64'(dump_q[i]), 64'(dm_mem[(base + i) % 256]));
        end
    endtask

    initial begin
        int r, stop;
        rst = 1'b1; cfg_go = 1'b0; prog_len = '0; dump_base = '0; dump_len = '0;
        ld_valid = 1'b0; ld_data = '0; ps_stop = 1'b0; dp_ready = 1'b0; dm_r_data = '0;
        for (int i = 0; i < 256; i++) dm_mem[i] = DW'($urandom);
        repeat (3) tick();
        chk_rst_outs("por");
        rst = 1'b0;
        tick();

        run_seq(3, 0, 0, 1, 100, 100, -1, 16'hA001, 0);
        run_seq(2, 0, 0, 40, 100, 100, -1, '0, 0);
        dm_mem[254] = 16'h1111; dm_mem[255] = 16'h2222; dm_mem[0] = 16'h3333;
        run_seq(1, 254, 3, 7, 100, 100, 1, '0, 0);
        run_seq(0, 0, 0, 10, 100, 100, -1, '0, 0);
        run_seq(1, 0, 2, 0, 100, 100, -1, '0, 0);
        run_seq(2, 3, 2, 63, 100, 100, -1, '0, 0);

        run_seq(5, 0, 0, 10, 100, 100, -1, '0, 1);
        ld_valid = 1'b0; rst = 1'b1; cfg_go = 1'b1;
        tick();
        chk_rst_outs("rst_load");
        rst = 1'b0; cfg_go = 1'b0;
        tick();
        chk("idle_after_rst_load", 64'({busy, ld_ready, done, err}), 64'd0);

        run_seq(2, 10, 4, 6, 100, 100, -1, '0, 2);
        ps_stop = 1'b0; rst = 1'b1; cfg_go = 1'b1;
        tick();
        chk_rst_outs("rst_dump");
        rst = 1'b0; cfg_go = 1'b0;
        tick();
        chk("idle_after_rst_dump", 64'({busy, dm_sel, dp_valid, done, err}), 64'd0);

        for (int n = 0; n < 8; n++) begin
            r = int'($urandom_range(9));
            stop = (r == 0) ? 0 : (r == 1) ? 70 : int'($urandom_range(62, 1));
            run_seq(int'($urandom_range(12)), int'($urandom_range(255)), int'($urandom_range(5)), stop,
                    int'($urandom_range(100, 50)), int'($urandom_range(100, 30)), -1, '0, 0);
        end
        run_seq(300, int'($urandom_range(255)), 290, 20, 100, 100, -1, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
